// File: rtl/trace_draw_sequencer.sv
// Oscilloscope trace draw sequencer: optional screen clear, then one
// column per divider period with two pixel writes (trace 1, trace 2).
module trace_draw_sequencer #(
  parameter int VGA_WIDTH  = 640,
  parameter int VGA_HEIGHT = 480,
  parameter int SAMPLE_DIV = 32
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       start,
  input  logic       clear_first,
  input  logic [8:0] sample_y1,
  input  logic [8:0] sample_y2,
  output logic       step,
  output logic [9:0] wr_x,
  output logic [8:0] wr_y,
  output logic       wr_en,
  output logic [1:0] wr_color,
  output logic       busy,
  output logic       done
);

  localparam int DW = (SAMPLE_DIV > 2) ? $clog2(SAMPLE_DIV) : 2;
  localparam logic [DW-1:0] DIV_TOP = DW'(SAMPLE_DIV - 1);
  localparam logic [9:0] XMAX = 10'(VGA_WIDTH - 1);
  localparam logic [8:0] YMAX = 9'(VGA_HEIGHT - 1);
  localparam logic [9:0] YLIM = 10'(VGA_HEIGHT);

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_WAIT, S_W1, S_W2, S_DONE
  } state_t;

  state_t state_q, state_d;
  logic [9:0] col_q, col_d;
  logic [DW-1:0] div_q, div_d;
  logic [8:0] y1_q, y1_d, y2_q, y2_d;
  logic [9:0] cx_q, cx_d;
  logic [8:0] cy_q, cy_d;
  logic step_q, step_d, wr_en_q, wr_en_d;
  logic [9:0] wr_x_q, wr_x_d;
  logic [8:0] wr_y_q, wr_y_d;
  logic [1:0] wr_color_q, wr_color_d;
  logic busy_q, busy_d, done_q, done_d;

  // Next state plus outputs for the cycle being entered. The divider
  // reloads at the step and keeps counting through W1/W2, so the step
  // period stays SAMPLE_DIV clocks including the two write cycles.
  always_comb begin
    state_d    = state_q;
    col_d      = col_q;
    div_d      = div_q;
    y1_d       = y1_q;
    y2_d       = y2_q;
    cx_d       = cx_q;
    cy_d       = cy_q;
    step_d     = 1'b0;
    wr_en_d    = 1'b0;
    wr_x_d     = '0;
    wr_y_d     = '0;
    wr_color_d = 2'b00;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          col_d = '0;
          div_d = DIV_TOP;
          cx_d  = '0;
          cy_d  = '0;
          if (clear_first) begin
            state_d = S_CLEAR;
            wr_en_d = 1'b1;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_CLEAR: begin
        if (cx_q == XMAX && cy_q == YMAX) begin
          state_d = S_WAIT;
        end else begin
          if (cx_q == XMAX) begin
            cx_d = '0;
            cy_d = cy_q + 9'd1;
          end else begin
            cx_d = cx_q + 10'd1;
          end
          wr_en_d = 1'b1;
          wr_x_d  = cx_d;
          wr_y_d  = cy_d;
        end
      end
      S_WAIT: begin
        if (div_q == '0) begin
          state_d    = S_W1;
          div_d      = DIV_TOP;
          y1_d       = sample_y1;
          y2_d       = sample_y2;
          wr_en_d    = ({1'b0, sample_y1} < YLIM);
          wr_x_d     = col_q;
          wr_y_d     = sample_y1;
          wr_color_d = 2'b01;
        end else begin
          div_d  = div_q - 1'b1;
          step_d = (div_d == '0);
        end
      end
      S_W1: begin
        state_d    = S_W2;
        div_d      = div_q - 1'b1;
        wr_en_d    = ({1'b0, y2_q} < YLIM);
        wr_x_d     = col_q;
        wr_y_d     = y2_q;
        wr_color_d = 2'b10;
      end
      S_W2: begin
        if (col_q == XMAX) begin
          state_d = S_DONE;
          div_d   = '0;
        end else begin
          state_d = S_WAIT;
          col_d   = col_q + 10'd1;
          div_d   = div_q - 1'b1;
          step_d  = (div_d == '0);
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d == S_CLEAR) || (state_d == S_WAIT) ||
             (state_d == S_W1) || (state_d == S_W2);
    done_d = (state_d == S_DONE);
  end

  // State, counters, latched rows and registered outputs.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      col_q      <= '0;
      div_q      <= '0;
      y1_q       <= '0;
      y2_q       <= '0;
      cx_q       <= '0;
      cy_q       <= '0;
      step_q     <= 1'b0;
      wr_en_q    <= 1'b0;
      wr_x_q     <= '0;
      wr_y_q     <= '0;
      wr_color_q <= 2'b00;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      col_q      <= col_d;
      div_q      <= div_d;
      y1_q       <= y1_d;
      y2_q       <= y2_d;
      cx_q       <= cx_d;
      cy_q       <= cy_d;
      step_q     <= step_d;
      wr_en_q    <= wr_en_d;
      wr_x_q     <= wr_x_d;
      wr_y_q     <= wr_y_d;
      wr_color_q <= wr_color_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign step     = step_q;
  assign wr_en    = wr_en_q;
  assign wr_x     = wr_x_q;
  assign wr_y     = wr_y_q;
  assign wr_color = wr_color_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_trace_draw_sequencer.sv
// Directed bench for trace_draw_sequencer at 4x2 screen, divider 3.
// Per-cycle output vectors are compared against a timing table.
module tb_trace_draw_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       clear_first;
  logic [8:0] sample_y1;
  logic [8:0] sample_y2;
  logic       step;
  logic [9:0] wr_x;
  logic [8:0] wr_y;
  logic       wr_en;
  logic [1:0] wr_color;
  logic       busy;
  logic       done;

  int vectors = 0;
  int miscompares = 0;

  trace_draw_sequencer #(
    .VGA_WIDTH(4), .VGA_HEIGHT(2), .SAMPLE_DIV(3)
  ) dut (
    .CLOCK_50(clk), .reset(reset), .start(start),
    .clear_first(clear_first), .sample_y1(sample_y1),
    .sample_y2(sample_y2), .step(step), .wr_x(wr_x),
    .wr_y(wr_y), .wr_en(wr_en), .wr_color(wr_color),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // {step, wr_en, busy, done, x, y, color}; x/y/color only when writing
  function automatic logic [24:0] obs_vec();
    logic [20:0] w;
    w = wr_en ? {wr_x, wr_y, wr_color} : 21'd0;
    return {step, wr_en, busy, done, w};
  endfunction

  // Expected vector k cycles after the start edge.
  // Clear: k=1..8 pixels. Sweep (kp=k-off): steps at kp=3,6,9,12,
  // W1 one cycle after, W2 two after, DONE from kp=15.
  function automatic logic [24:0] exp_vec(int k, bit clr, int y1, int y2);
    int off, kp, m, col, ph;
    logic s, e, b, d;
    logic [9:0] x;
    logic [8:0] y;
    logic [1:0] c;
    s = 0; e = 0; b = 0; d = 0; x = 0; y = 0; c = 0;
    off = clr ? 8 : 0;
    kp = k - off;
    if (clr && k >= 1 && k <= 8) begin
      e = 1; b = 1;
      x = 10'((k - 1) % 4);
      y = 9'((k - 1) / 4);
    end else if (kp >= 1 && kp <= 14) begin
      b = 1;
      if (kp >= 3) begin
        m = kp - 3;
        col = m / 3;
        ph = m % 3;
        if (ph == 0) s = 1;
        else if (ph == 1 && y1 < 2) begin
          e = 1; x = 10'(col); y = 9'(y1); c = 2'b01;
        end else if (ph == 2 && y2 < 2) begin
          e = 1; x = 10'(col); y = 9'(y2); c = 2'b10;
        end
      end
    end else if (kp >= 15) begin
      d = 1;
    end
    return {s, e, b, d, x, y, c};
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    clear_first = 1'b0;
    sample_y1 = 9'd0;
    sample_y2 = 9'd0;
    repeat (3) @(negedge clk);
    vectors++;
    if ({step, wr_en, busy, done, wr_x, wr_y, wr_color} !== 25'd0) begin
      miscompares++;
      $display("FAIL reset_outputs got=%h want=0",
               {step, wr_en, busy, done, wr_x, wr_y, wr_color});
    end
    reset = 1'b0;
    repeat (5) @(negedge clk);
    vectors++;
    if (obs_vec() !== 25'd0) begin
      miscompares++;
      $display("FAIL idle_after_reset got=%h want=0", obs_vec());
    end
  endtask

  task automatic test_clear_sweep();
    logic [24:0] o, x;
    sample_y1 = 9'd1;
    sample_y2 = 9'd0;
    clear_first = 1'b1;
    start = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 24; k++) begin
      @(negedge clk);
      start = 1'b0;
      o = obs_vec();
      x = exp_vec(k, 1'b1, 1, 0);
      vectors++;
      if (o !== x) begin
        miscompares++;
        $display("FAIL clear_sweep k=%0d got=%h want=%h", k, o, x);
      end
    end
  endtask

  task automatic test_sweep(int y1, int y2, string nm);
    logic [24:0] o, x;
    sample_y1 = 9'(y1);
    sample_y2 = 9'(y2);
    clear_first = 1'b0;
    start = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      start = 1'b0;
      o = obs_vec();
      x = exp_vec(k, 1'b0, y1, y2);
      vectors++;
      if (o !== x) begin
        miscompares++;
        $display("FAIL %s k=%0d got=%h want=%h", nm, k, o, x);
      end
    end
  endtask

  task automatic test_start_ignored();
    logic [24:0] o, x;
    sample_y1 = 9'd0;
    sample_y2 = 9'd1;
    clear_first = 1'b0;
    start = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      o = obs_vec();
      x = exp_vec(k, 1'b0, 0, 1);
      vectors++;
      if (o !== x) begin
        miscompares++;
        $display("FAIL start_ignored k=%0d got=%h want=%h", k, o, x);
      end
      start = (k == 9);
      clear_first = (k == 9);
    end
    clear_first = 1'b0;
  endtask

  task automatic test_reset_mid_clear();
    clear_first = 1'b1;
    start = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      start = 1'b0;
    end
    vectors++;
    if ({wr_en, wr_x, wr_y} !== {1'b1, 10'd1, 9'd1}) begin
      miscompares++;
      $display("FAIL clear_pixel5 got=%h want=%h",
               {wr_en, wr_x, wr_y}, {1'b1, 10'd1, 9'd1});
    end
    #2 reset = 1'b1;
    #1;
    vectors++;
    if ({step, wr_en, busy, done, wr_x, wr_y, wr_color} !== 25'd0) begin
      miscompares++;
      $display("FAIL async_reset got=%h want=0",
               {step, wr_en, busy, done, wr_x, wr_y, wr_color});
    end
    @(negedge clk);
    reset = 1'b0;
    clear_first = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      vectors++;
      if ({step, wr_en, busy, done} !== 4'd0) begin
        miscompares++;
        $display("FAIL post_reset_idle k=%0d got=%b want=0000",
                 k, {step, wr_en, busy, done});
      end
    end
  endtask

  initial begin
    test_reset();
    test_clear_sweep();
    test_sweep(1, 0, "sweep_from_done");
    test_sweep(1, 0, "sweep_again");
    test_sweep(5, 1, "y1_out_of_range");
    test_start_ignored();
    test_reset_mid_clear();
    test_sweep(0, 1, "sweep_after_reset");
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
